rgb_expand_pipe: RTL and testbench
==================================

Name: rgb_expand_pipe

Overview:
- Parametrised, pipelined successor to the combinational RGB444->RGB888 VGA colour stage.
- Expands IN_BITS-per-channel pixels to OUT_BITS-per-channel by bit replication.
- Adds frame-synchronous mode selection (passthrough, grayscale, colour bars, blank) and delays hsync/vsync/nblank to stay aligned with the pixel data.
- Sits between the frame-buffer read port and the VGA DAC pins.

Parameters:
- IN_BITS, 4, bits per channel on din_i; legal range 1..OUT_BITS.
- OUT_BITS, 8, bits per channel on r_o/g_o/b_o.
- BAR_W, 80, colour-bar width in active pixels; must be >=1.
- SYNC_IDLE, 1, inactive level of hsync/vsync; reset value of hs_o/vs_o.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- din_i  in  3*IN_BITS  pixel {R,G,B}, R in MSBs
- nblank_i  in  1  1 = active video
- hs_i  in  1  horizontal sync, raw
- vs_i  in  1  vertical sync, raw
- mode_i  in  2  requested mode: 0 pass, 1 gray, 2 bars, 3 black
- r_o, g_o, b_o  out  OUT_BITS each  expanded colour
- nblank_o, hs_o, vs_o  out  1 each  syncs delayed to match colour
- mode_o  out  2  mode currently in effect

Behaviour:
- Reset (rst=1 at a clk edge): r/g/b_o=0, nblank_o=0, hs_o=vs_o=SYNC_IDLE, mode_o=0. Column counters, bar index and pipeline registers cleared.
- Reset mid-frame: outputs return to the reset values on the next edge; the pipeline refills with no garbage pixel emitted.
- Latency: exactly 2 clk from din_i/nblank_i/hs_i/vs_i to outputs, for every mode.
- Stage 1 registers:
  - the expanded channels;
  - the bar colour;
  - nblank, hs and vs.
- Stage 2 applies the mode mux and the blank gate.
- Expansion rule: out[OUT_BITS-1-k] = in[IN_BITS-1-(k mod IN_BITS)], i.e. MSB-first repetition, truncated.
  - IN=4: 1101 -> 11011101.
  - IN=5: 10110 -> 10110101.
  - IN=OUT: identity.
- Gray (mode 1): Y = (2R + 5G + B) >> 3, using expanded OUT_BITS values.
  - Intermediate width is OUT_BITS+3; the result cannot overflow.
  - r_o = g_o = b_o = Y.
- Bars (mode 2): din_i ignored.
  - px_cnt counts 0..BAR_W-1 while nblank_i=1. On wrap, bar_idx increments, saturating at 7.
  - Both counters clear on any cycle with nblank_i=0.
  - Each channel is all-ones or zero: R=~idx[1], G=~idx[2], B=~idx[0].
  - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
- Black (mode 3): all channels 0; syncs still pass.
- Blank gate: whenever the delayed nblank is 0, r/g/b_o = 0, regardless of mode.
- Mode latching: active mode register loads mode_i only on the vsync assertion edge (vs_i != SYNC_IDLE while the previous vs_i == SYNC_IDLE).
  - mode_o shows the active mode.
  - A mid-frame mode_i change has no effect until the next vsync edge, so there is no tearing.
- Simultaneous vsync edge and rst: rst wins, and the mode stays 0.

Optional Feature:
- Macro RGB_BAR_SCROLL_EN.
- Defined:
  - a 3-bit frame counter increments on every vsync assertion edge and clears on rst;
  - the bar colour index becomes (bar_idx + frame_cnt) mod 8, so the bars move one bar per frame.
- Not defined: no frame counter; bars are static.

Decomposition:
- Shared header vga_defs.vh holds:
  - mode constants MODE_PASS=0, MODE_GRAY=1, MODE_BARS=2, MODE_BLACK=3;
  - luma weights 2/5/1 and shift 3.
- Sub-module rgb_chan_expand (params IN_BITS, OUT_BITS) is purely combinational replication. It is instantiated 3x in stage 1.

Test Plan:
- Reset/latency. IN=4, OUT=8, mode 0:
  - hold rst 3 cycles -> outputs 0, hs_o=vs_o=1;
  - release, drive din_i=12'hD3A with nblank=1 -> 2 cycles later r_o=DD, g_o=33, b_o=AA.
- Blank gate: din_i=12'hFFF with nblank_i=0 -> r/g/b_o=00 and nblank_o=0 after 2 cycles.
- Gray:
  - mode_i=1 latched at a vsync edge, din_i=12'hF00 -> Y=(2*255)>>3=63 (0x3F) on all channels;
  - din_i=12'hFFF -> 0xFF.
- Bars, BAR_W=4, mode 2:
  - 32 active pixels -> 4 pixels each of FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000;
  - pixel 33+ stays 000000;
  - with RGB_BAR_SCROLL_EN, the next frame starts at FFFF00.
- Mode latch: switch mode_i 0->3 mid-line -> colours unchanged until the vs_i 1->0 edge; next active pixel is black and mode_o=3.
- Width generalisation: IN=5, OUT=8, R=5'b10110 -> r_o=8'b10110101.

Source files
------------

// File: rtl/rgb_expand_pipe_pkg.sv
// Shared definitions for the RGB expansion pipeline: mode encoding, luma weights
// and the colour-bar palette rule.
package rgb_expand_pipe_pkg;

   localparam int unsigned MODE_W     = 2;
   localparam int unsigned BAR_IDX_W  = 3;
   localparam int unsigned LUMA_R     = 2;
   localparam int unsigned LUMA_G     = 5;
   localparam int unsigned LUMA_B     = 1;
   localparam int unsigned LUMA_SHIFT = 3;
   localparam int unsigned LUMA_GROW  = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_PASS  = 2'd0,
      MODE_GRAY  = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_BLACK = 2'd3
   } mode_e;

   localparam logic [BAR_IDX_W-1:0] BAR_IDX_LAST = 3'd7;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } bar_rgb_t;

   // Palette order: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic bar_rgb_t bar_colour(input logic [BAR_IDX_W-1:0] idx);
      bar_rgb_t c;
      c.r = ~idx[1];
      c.g = ~idx[2];
      c.b = ~idx[0];
      return c;
   endfunction

endpackage

// File: rtl/rgb_chan_expand.sv
// Combinational per-channel width expansion by MSB-first bit replication,
// truncated to OUT_BITS.
module rgb_chan_expand #(
   parameter int unsigned IN_BITS  = 4,
   parameter int unsigned OUT_BITS = 8
) (
   input  logic [IN_BITS-1:0]  din,
   output logic [OUT_BITS-1:0] dout_c
);

   for (genvar k = 0; k < OUT_BITS; k++) begin : g_bit
      assign dout_c[OUT_BITS-1-k] = din[IN_BITS-1-(k % IN_BITS)];
   end

endmodule

// File: rtl/rgb_expand_pipe.sv
// Two-stage RGB expansion pipeline with frame-synchronous mode select
// (pass/gray/bars/black). Define RGB_BAR_SCROLL_EN to scroll the bars one per frame.
module rgb_expand_pipe
   import rgb_expand_pipe_pkg::*;
#(
   parameter int unsigned IN_BITS   = 4,
   parameter int unsigned OUT_BITS  = 8,
   parameter int unsigned BAR_W     = 80,
   parameter logic        SYNC_IDLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3*IN_BITS-1:0]  din_i,
   input  logic                  nblank_i,
   input  logic                  hs_i,
   input  logic                  vs_i,
   input  logic [MODE_W-1:0]     mode_i,
   output logic [OUT_BITS-1:0]   r_o,
   output logic [OUT_BITS-1:0]   g_o,
   output logic [OUT_BITS-1:0]   b_o,
   output logic                  nblank_o,
   output logic                  hs_o,
   output logic                  vs_o,
   output logic [MODE_W-1:0]     mode_o
);

   localparam int unsigned PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int unsigned Y_W  = OUT_BITS + LUMA_GROW;

   logic [OUT_BITS-1:0]  r_exp, g_exp, b_exp;
   logic                 vs_prev;
   logic                 vs_edge;
   mode_e                mode_q;
   logic [PX_W-1:0]      px_cnt;
   logic [BAR_IDX_W-1:0] bar_idx;
   logic [BAR_IDX_W-1:0] bar_sel;

   logic [OUT_BITS-1:0]  r1, g1, b1;
   bar_rgb_t             bar1;
   logic                 nb1, hs1, vs1;

   logic [Y_W-1:0]       y_sum;
   logic [OUT_BITS-1:0]  y_val;
   logic [OUT_BITS-1:0]  r_nx, g_nx, b_nx;

   rgb_chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_r (
      .din    (din_i[3*IN_BITS-1 -: IN_BITS]),
      .dout_c (r_exp)
   );

   rgb_chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_g (
      .din    (din_i[2*IN_BITS-1 -: IN_BITS]),
      .dout_c (g_exp)
   );

   rgb_chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_b (
      .din    (din_i[IN_BITS-1:0]),
      .dout_c (b_exp)
   );

   assign vs_edge = (vs_i != SYNC_IDLE) && (vs_prev == SYNC_IDLE);

   // Mode only changes on the vsync assertion edge so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev <= SYNC_IDLE;
         mode_q  <= MODE_PASS;
      end else begin
         vs_prev <= vs_i;
         if (vs_edge) begin
            mode_q <= mode_e'(mode_i);
         end
      end
   end

   assign mode_o = mode_q;

   // Column position within the active line; bar index saturates on the last bar.
   always_ff @(posedge clk) begin
      if (rst || !nblank_i) begin
         px_cnt  <= '0;
         bar_idx <= '0;
      end else if (px_cnt == PX_W'(BAR_W - 1)) begin
         px_cnt <= '0;
         if (bar_idx != BAR_IDX_LAST) begin
            bar_idx <= bar_idx + BAR_IDX_W'(1);
         end
      end else begin
         px_cnt <= px_cnt + PX_W'(1);
      end
   end

`ifdef RGB_BAR_SCROLL_EN
   logic [BAR_IDX_W-1:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (vs_edge) begin
         frame_cnt <= frame_cnt + BAR_IDX_W'(1);
      end
   end

   assign bar_sel = bar_idx + frame_cnt;
`else
   assign bar_sel = bar_idx;
`endif

   // Stage 1: expanded channels, bar colour and delayed syncs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1   <= '0;
         g1   <= '0;
         b1   <= '0;
         bar1 <= '0;
         nb1  <= 1'b0;
         hs1  <= SYNC_IDLE;
         vs1  <= SYNC_IDLE;
      end else begin
         r1   <= r_exp;
         g1   <= g_exp;
         b1   <= b_exp;
         bar1 <= bar_colour(bar_sel);
         nb1  <= nblank_i;
         hs1  <= hs_i;
         vs1  <= vs_i;
      end
   end

   // Stage 2 select: mode mux followed by the blank gate.
   always_comb begin
      y_sum = Y_W'(LUMA_R) * Y_W'(r1)
            + Y_W'(LUMA_G) * Y_W'(g1)
            + Y_W'(LUMA_B) * Y_W'(b1);
      y_val = OUT_BITS'(y_sum >> LUMA_SHIFT);
      r_nx  = '0;
      g_nx  = '0;
      b_nx  = '0;
      case (mode_q)
         MODE_PASS: begin
            r_nx = r1;
            g_nx = g1;
            b_nx = b1;
         end
         MODE_GRAY: begin
            r_nx = y_val;
            g_nx = y_val;
            b_nx = y_val;
         end
         MODE_BARS: begin
            r_nx = {OUT_BITS{bar1.r}};
            g_nx = {OUT_BITS{bar1.g}};
            b_nx = {OUT_BITS{bar1.b}};
         end
         MODE_BLACK: begin
            r_nx = '0;
            g_nx = '0;
            b_nx = '0;
         end
      endcase
      if (!nb1) begin
         r_nx = '0;
         g_nx = '0;
         b_nx = '0;
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_o      <= '0;
         g_o      <= '0;
         b_o      <= '0;
         nblank_o <= 1'b0;
         hs_o     <= SYNC_IDLE;
         vs_o     <= SYNC_IDLE;
      end else begin
         r_o      <= r_nx;
         g_o      <= g_nx;
         b_o      <= b_nx;
         nblank_o <= nb1;
         hs_o     <= hs1;
         vs_o     <= vs1;
      end
   end

endmodule

// File: tb/tb_rgb_expand_pipe.sv
// Self-checking bench for rgb_expand_pipe: constant vectors, corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_rgb_expand_pipe;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] din;
   logic        nb, hs, vs;
   logic [1:0]  mode_i;
   logic [7:0]  r, g, b;
   logic        nbo, hso, vso;
   logic [1:0]  mode_o;

   logic [14:0] din5;
   logic [7:0]  r5, g5, b5;
   logic        nb5, hs5, vs5;
   logic [1:0]  mode5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rgb_expand_pipe #(.IN_BITS(4), .OUT_BITS(8), .BAR_W(BW), .SYNC_IDLE(1'b1)) dut (
      .clk(clk), .rst(rst), .din_i(din), .nblank_i(nb), .hs_i(hs), .vs_i(vs),
      .mode_i(mode_i), .r_o(r), .g_o(g), .b_o(b), .nblank_o(nbo), .hs_o(hso),
      .vs_o(vso), .mode_o(mode_o)
   );

   rgb_expand_pipe #(.IN_BITS(5), .OUT_BITS(8), .BAR_W(BW), .SYNC_IDLE(1'b1)) dut5 (
      .clk(clk), .rst(rst), .din_i(din5), .nblank_i(nb), .hs_i(hs), .vs_i(vs),
      .mode_i(mode_i), .r_o(r5), .g_o(g5), .b_o(b5), .nblank_o(nb5), .hs_o(hs5),
      .vs_o(vs5), .mode_o(mode5)
   );

   logic [23:0] bar_tab [8];

   typedef struct {
      logic        rst;
      logic [11:0] din;
      logic        nb, hs, vs;
      logic [23:0] bar;
   } rec_t;

   rec_t       prev;
   int         run;
   int         frame;
   logic [1:0] m_mode;
   logic       m_vs_prev;
   logic [7:0] er, eg, eb;
   logic       enb, ehs, evs;
   logic [1:0] emode;

   // Replicate the value end to end and keep the top 8 bits.
   function automatic logic [7:0] expand(input logic [4:0] v, input int inb);
      logic [63:0] t;
      t = 64'd0;
      for (int i = 0; i < 8; i++) t = (t << inb) | 64'(v);
      return 8'(t >> (8 * inb - 8));
   endfunction

   function automatic logic [7:0] luma(input logic [7:0] rr, gg, bb);
      return 8'((2 * int'(rr) + 5 * int'(gg) + int'(bb)) / 8);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Reference behaviour for one clock edge, using the inputs present at that edge.
   task automatic model_edge();
      rec_t       cur;
      logic [1:0] mode_old;
      logic [7:0] pr, pg, pb, y;
      int         idx;
      mode_old = m_mode;
      cur.rst = rst; cur.din = din; cur.nb = nb; cur.hs = hs; cur.vs = vs; cur.bar = 24'h0;
      if (rst) begin
         m_mode = 2'd0; frame = 0; run = 0; m_vs_prev = 1'b1;
      end else begin
         idx = run / BW;
         if (idx > 7) idx = 7;
`ifdef RGB_BAR_SCROLL_EN
         idx = (idx + frame) % 8;
`endif
         cur.bar = bar_tab[idx];
         run = nb ? run + 1 : 0;
         if (vs == 1'b0 && m_vs_prev == 1'b1) begin
            m_mode = mode_i;
            frame++;
         end
         m_vs_prev = vs;
      end
      emode = m_mode;
      if (rst || prev.rst) begin
         er = 8'h0; eg = 8'h0; eb = 8'h0; enb = 1'b0; ehs = 1'b1; evs = 1'b1;
      end else begin
         enb = prev.nb; ehs = prev.hs; evs = prev.vs;
         pr = expand({1'b0, prev.din[11:8]}, 4);
         pg = expand({1'b0, prev.din[7:4]}, 4);
         pb = expand({1'b0, prev.din[3:0]}, 4);
         y  = luma(pr, pg, pb);
         case (mode_old)
            2'd0: begin er = pr; eg = pg; eb = pb; end
            2'd1: begin er = y; eg = y; eb = y; end
            2'd2: begin er = prev.bar[23:16]; eg = prev.bar[15:8]; eb = prev.bar[7:0]; end
            default: begin er = 8'h0; eg = 8'h0; eb = 8'h0; end
         endcase
         if (!prev.nb) begin er = 8'h0; eg = 8'h0; eb = 8'h0; end
      end
      prev = cur;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model", {3'b0, r, g, b, nbo, hso, vso, mode_o},
                   {3'b0, er, eg, eb, enb, ehs, evs, emode});
   endtask

   task automatic vsync_pulse(input logic [1:0] m);
      mode_i = m; vs = 1'b0; nb = 1'b0; din = 12'h0;
      tick();
      vs = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [11:0] din;
      logic        nb;
      logic [1:0]  mode;
      logic [7:0]  er, eg, eb;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [23:0] q[$];
      logic [23:0] expc;
      int          fr, bi;

      bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF;
      bar_tab[3] = 24'h00FF00; bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
      bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

      vecs[0] = '{12'hD3A, 1'b1, 2'd0, 8'hDD, 8'h33, 8'hAA};
      vecs[1] = '{12'hFFF, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{12'hF00, 1'b1, 2'd1, 8'h3F, 8'h3F, 8'h3F};
      vecs[3] = '{12'hFFF, 1'b1, 2'd1, 8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{12'h0F0, 1'b1, 2'd1, 8'h9F, 8'h9F, 8'h9F};
      vecs[5] = '{12'h00F, 1'b1, 2'd1, 8'h1F, 8'h1F, 8'h1F};
      vecs[6] = '{12'hFFF, 1'b0, 2'd1, 8'h00, 8'h00, 8'h00};
      vecs[7] = '{12'h123, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00};
      vecs[8] = '{12'h8C4, 1'b1, 2'd0, 8'h88, 8'hCC, 8'h44};

      prev.rst = 1'b1; prev.din = 12'h0; prev.nb = 1'b0; prev.hs = 1'b1; prev.vs = 1'b1;
      prev.bar = 24'h0;
      run = 0; frame = 0; m_mode = 2'd0; m_vs_prev = 1'b1;

      rst = 1'b1; din = 12'h0; nb = 1'b0; hs = 1'b1; vs = 1'b1; mode_i = 2'd0;
      din5 = {5'b10110, 5'b01001, 5'b11111};

      repeat (3) tick();
      chk("reset_rgb", {8'h0, r, g, b}, 32'h0);
      chk("reset_sync", {29'h0, nbo, hso, vso}, {29'h0, 3'b011});
      chk("reset_mode", {30'h0, mode_o}, 32'h0);
      rst = 1'b0;

      // Constant vectors: latch mode, push one pixel, look two clocks later.
      for (int i = 0; i < 9; i++) begin
         vsync_pulse(vecs[i].mode);
         din = vecs[i].din; nb = vecs[i].nb;
         tick();
         din = 12'h0; nb = 1'b0;
         tick();
         chk($sformatf("vec%0d_rgb", i), {8'h0, r, g, b},
             {8'h0, vecs[i].er, vecs[i].eg, vecs[i].eb});
         chk($sformatf("vec%0d_nblank", i), {31'h0, nbo}, {31'h0, vecs[i].nb});
         chk($sformatf("vec%0d_mode", i), {30'h0, mode_o}, {30'h0, vecs[i].mode});
         if (vecs[i].mode == 2'd0 && vecs[i].nb) begin
            chk("in5_rgb", {8'h0, r5, g5, b5}, {8'h0, 8'hB5, 8'h4A, 8'hFF});
         end
      end

      // Colour bars over one long active run.
      vsync_pulse(2'd2);
      fr = frame;
      tick();
      nb = 1'b1;
      for (int i = 0; i < 36; i++) begin
         din = 12'($urandom);
         tick();
         if (nbo) q.push_back({r, g, b});
      end
      nb = 1'b0;
      tick();
      if (nbo) q.push_back({r, g, b});
      if (nbo == 1'b0 && q.size() < 36) q.push_back({r, g, b});
      chk("bar_count", 32'(q.size()), 32'd36);
      for (int i = 0; i < q.size() && i < 36; i++) begin
         bi = (i / BW > 7) ? 7 : i / BW;
`ifdef RGB_BAR_SCROLL_EN
         bi = (bi + fr) % 8;
`endif
         expc = bar_tab[bi];
         chk($sformatf("bar_px%0d", i), {8'h0, q[i]}, {8'h0, expc});
      end

      // Mid-line mode change has no effect until the vsync edge.
      vsync_pulse(2'd0);
      nb = 1'b1; din = 12'hD3A;
      repeat (4) tick();
      mode_i = 2'd3;
      repeat (4) tick();
      chk("latch_hold_r", {24'h0, r}, 32'hDD);
      chk("latch_hold_mode", {30'h0, mode_o}, 32'd0);
      vs = 1'b0;
      tick();
      chk("latch_mode_now", {30'h0, mode_o}, 32'd3);
      vs = 1'b1;
      tick();
      chk("latch_black", {8'h0, r, g, b}, 32'h0);
      chk("latch_nblank", {31'h0, nbo}, 32'd1);

      // Reset in the middle of active video.
      vsync_pulse(2'd2);
      nb = 1'b1;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      chk("midrst_mode", {30'h0, mode_o}, 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_clean", {8'h0, r, g, b}, 32'h0);
      chk("midrst_nblank", {31'h0, nbo}, 32'd0);
      repeat (3) tick();

      // Randomized traffic.
      begin
         int left;
         left = 0;
         for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (left == 0) begin
               nb = ~nb;
               left = nb ? $urandom_range(1, 40) : $urandom_range(1, 8);
            end
            left--;
            din = 12'($urandom);
            hs = 1'($urandom);
            if ($urandom_range(0, 49) == 0) vs = ~vs;
            if ($urandom_range(0, 9) == 0) mode_i = 2'($urandom);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
